// File: rtl/keypad_pkg.sv
// Shared constants, state encodings and key decode helpers for the keypad
// command encoder and its matrix scanner.
package keypad_pkg;

    localparam logic [3:0] KP_NONE   = 4'b0000;
    localparam logic [3:0] KP_ARM    = 4'b0011;
    localparam logic [3:0] KP_DISARM = 4'b1100;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} scan_state_t;
    typedef enum logic {IDLE, COLLECT} entry_state_t;

    // Indexed by {row, col}
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1,     4'h2, 4'h3,     KEY_A,
        4'h4,     4'h5, 4'h6,     KEY_B,
        4'h7,     4'h8, 4'h9,     KEY_C,
        KEY_STAR, 4'h0, KEY_HASH, KEY_D
    };

    function automatic logic [3:0] key_lookup(input logic [3:0] rows, input logic [1:0] col);
        logic [1:0] r;
        if (!rows[0])      r = 2'd0;
        else if (!rows[1]) r = 2'd1;
        else if (!rows[2]) r = 2'd2;
        else               r = 2'd3;
        return KEY_MAP[{r, col}];
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_code_encoder_if.sv
// Keypad pins and siren-side command bus of the keypad code encoder.
interface keypad_code_encoder_if;
    logic       ENA;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] keypad;
    logic       bad_pin;
    logic [2:0] digit_cnt;
    logic       locked;

    modport master (
        input  ENA, row_n,
        output col_n, keypad, bad_pin, digit_cnt, locked
    );

    modport slave (
        output ENA, row_n,
        input  col_n, keypad, bad_pin, digit_cnt, locked
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix scanner: rotates the active-low column drive, debounces a press,
// decodes it to a key code and requires a debounced release before rescanning.
//
// state    | meaning
// SCAN     | rotating columns, waiting for any row low
// DEBOUNCE | column frozen, row pattern must hold DEB_TICKS ticks
// RELEASE  | waiting for DEB_TICKS consecutive all-high row ticks
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 2,
    parameter int DEB_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ena,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_evt,
    output logic [3:0] key_code
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DEB_W = $clog2(DEB_TICKS + 1);

    scan_state_t      state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [3:0]       row_s_q, row_s_d;
    logic             evt_q, evt_d;
    logic [3:0]       code_q, code_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SCAN;
            col_q   <= '0;
            div_q   <= DIV_W'(SCAN_DIV - 1);
            deb_q   <= '0;
            row_s_q <= 4'hF;
            evt_q   <= 1'b0;
            code_q  <= '0;
        end else if (ena) begin
            state_q <= state_d;
            col_q   <= col_d;
            div_q   <= div_d;
            deb_q   <= deb_d;
            row_s_q <= row_s_d;
            evt_q   <= evt_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        div_d   = div_q;
        deb_d   = deb_q;
        row_s_d = row_s_q;
        evt_d   = 1'b0;
        code_d  = code_q;
        case (state_q)
            SCAN: begin
                if (row_n != 4'hF) begin
                    state_d = DEBOUNCE;
                    row_s_d = row_n;
                    deb_d   = DEB_W'(DEB_TICKS - 1);
                end else if (div_q == '0) begin
                    col_d = col_q + 2'd1;
                    div_d = DIV_W'(SCAN_DIV - 1);
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_n != row_s_q) begin
                    state_d = SCAN;
                    div_d   = DIV_W'(SCAN_DIV - 1);
                end else if (deb_q <= DEB_W'(1)) begin
                    evt_d   = 1'b1;
                    code_d  = key_lookup(row_s_q, col_q);
                    state_d = RELEASE;
                    deb_d   = DEB_W'(DEB_TICKS);
                end else begin
                    deb_d = deb_q - 1'b1;
                end
            end
            RELEASE: begin
                // Any row low restarts the release window, so a held key never repeats
                if (row_n != 4'hF) begin
                    deb_d = DEB_W'(DEB_TICKS);
                end else if (deb_q <= DEB_W'(1)) begin
                    state_d = SCAN;
                    div_d   = DIV_W'(SCAN_DIV - 1);
                end else begin
                    deb_d = deb_q - 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign col_n    = ~(4'b0001 << col_q);
    assign key_evt  = evt_q;
    assign key_code = code_q;

endmodule

// File: rtl/keypad_code_encoder.sv
// PIN entry front-end for the siren controller: collects digits from the
// scanner and issues ARM/DISARM. Define KEYPAD_LOCKOUT_EN for failed-attempt lockout.
//
// state   | meaning
// IDLE    | buffer empty
// COLLECT | one or more digits buffered
module keypad_code_encoder
    import keypad_pkg::*;
#(
    parameter logic [15:0] PIN       = 16'h1234,
    parameter int          SCAN_DIV  = 2,
    parameter int          DEB_TICKS = 4,
    parameter int          TIMEOUT   = 200
`ifdef KEYPAD_LOCKOUT_EN
    ,
    parameter int          MAX_FAIL      = 3,
    parameter int          LOCKOUT_TICKS = 250
`endif
) (
    input logic                   clk,
    input logic                   reset_n,
    keypad_code_encoder_if.master bus
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic         key_evt;
    logic [3:0]   key_code;

    entry_state_t state_q, state_d;
    logic [15:0]  buf_q, buf_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [3:0]   keypad_q, keypad_d;
    logic         bad_q, bad_d;
    logic [TO_W-1:0] to_q, to_d;
    logic         locked_q;

    keypad_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_TICKS (DEB_TICKS)
    ) u_scanner (
        .clk      (clk),
        .reset_n  (reset_n),
        .ena      (bus.ENA),
        .row_n    (bus.row_n),
        .col_n    (bus.col_n),
        .key_evt  (key_evt),
        .key_code (key_code)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            cnt_q    <= '0;
            keypad_q <= KP_NONE;
            bad_q    <= 1'b0;
            to_q     <= '0;
        end else if (bus.ENA) begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            keypad_q <= keypad_d;
            bad_q    <= bad_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        keypad_d = KP_NONE;
        bad_d    = 1'b0;
        to_d     = to_q;
        if (to_q != '0) to_d = to_q - 1'b1;
        if (to_q == TO_W'(1) && cnt_q != '0) begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end
        // A key on the timeout tick is evaluated against the uncleared buffer
        if (key_evt && !locked_q) begin
            to_d = TO_W'(TIMEOUT);
            if (is_digit(key_code)) begin
                buf_d   = {buf_q[11:0], key_code};
                cnt_d   = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
                state_d = COLLECT;
            end else if (key_code == KEY_C) begin
                buf_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end else if (key_code == KEY_A || key_code == KEY_B) begin
                if (cnt_q == 3'd4 && buf_q == PIN)
                    keypad_d = (key_code == KEY_A) ? KP_ARM : KP_DISARM;
                else
                    bad_d = 1'b1;
                buf_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                buf_d   = buf_q;
                cnt_d   = cnt_q;
                state_d = state_q;
            end
        end
    end

`ifdef KEYPAD_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_TICKS + 1);

    logic [FAIL_W-1:0] fail_q;
    logic [LOCK_W-1:0] lock_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_q     <= '0;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
        end else if (bus.ENA) begin
            if (locked_q) begin
                if (lock_cnt_q <= LOCK_W'(1)) begin
                    locked_q   <= 1'b0;
                    lock_cnt_q <= '0;
                    fail_q     <= '0;
                end else begin
                    lock_cnt_q <= lock_cnt_q - 1'b1;
                end
            end else if (keypad_d != KP_NONE) begin
                fail_q <= '0;
            end else if (bad_d) begin
                if (fail_q >= FAIL_W'(MAX_FAIL - 1)) begin
                    fail_q     <= FAIL_W'(MAX_FAIL);
                    locked_q   <= 1'b1;
                    lock_cnt_q <= LOCK_W'(LOCKOUT_TICKS);
                end else begin
                    fail_q <= fail_q + 1'b1;
                end
            end
        end
    end
`else
    assign locked_q = 1'b0;
`endif

    assign bus.keypad    = keypad_q;
    assign bus.bad_pin   = bad_q;
    assign bus.digit_cnt = cnt_q;
    assign bus.locked    = locked_q;

endmodule

// File: tb/tb_keypad_code_encoder.sv
// Scoreboard bench: stimulus queues expected siren commands, a monitor pops
// and compares whenever keypad or bad_pin becomes active.
module tb_keypad_code_encoder;
    import keypad_pkg::*;

    typedef struct packed {
        logic [3:0] kp;
        logic       bad;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    logic       pressed = 1'b0;
    logic [1:0] prow = '0;
    logic [1:0] pcol = '0;
    logic       bounce_en = 1'b0;
    logic [3:0] bounce_val = 4'hF;

    keypad_code_encoder_if bus();

    keypad_code_encoder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.row_n = bounce_en ? bounce_val :
                       (pressed && !bus.col_n[pcol]) ? ~(4'b0001 << prow) : 4'hF;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic locate(input logic [3:0] code);
        case (code)
            4'h1: begin prow = 0; pcol = 0; end
            4'h2: begin prow = 0; pcol = 1; end
            4'h3: begin prow = 0; pcol = 2; end
            4'hA: begin prow = 0; pcol = 3; end
            4'h4: begin prow = 1; pcol = 0; end
            4'h5: begin prow = 1; pcol = 1; end
            4'h6: begin prow = 1; pcol = 2; end
            4'hB: begin prow = 1; pcol = 3; end
            4'h7: begin prow = 2; pcol = 0; end
            4'h8: begin prow = 2; pcol = 1; end
            4'h9: begin prow = 2; pcol = 2; end
            4'hC: begin prow = 2; pcol = 3; end
            4'hE: begin prow = 3; pcol = 0; end
            4'h0: begin prow = 3; pcol = 1; end
            4'hF: begin prow = 3; pcol = 2; end
            default: begin prow = 3; pcol = 3; end
        endcase
    endtask

    task automatic press_hold(input logic [3:0] code, input int hold);
        @(negedge clk);
        locate(code);
        pressed = 1'b1;
        repeat (hold) @(negedge clk);
        pressed = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic press_seq(input logic [31:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) press_hold(seq[i*4 +: 4], 20);
    endtask

    task automatic expect_cmd(input logic [3:0] kp, input logic bad);
        exp_t e;
        e.kp  = kp;
        e.bad = bad;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_n && (bus.keypad != KP_NONE || bus.bad_pin)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_cmd: got keypad=%b bad_pin=%b expected no command",
                         bus.keypad, bus.bad_pin);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.keypad !== e.kp || bus.bad_pin !== e.bad) begin
                    failures++;
                    $display("FAIL cmd: got keypad=%b bad_pin=%b expected keypad=%b bad_pin=%b",
                             bus.keypad, bus.bad_pin, e.kp, e.bad);
                end
            end
        end
    end

    initial begin
        bus.ENA = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_col_n", 8'(bus.col_n), 8'hE);
        chk("reset_keypad", 8'(bus.keypad), 8'h0);
        chk("reset_bad_pin", 8'(bus.bad_pin), 8'h0);
        chk("reset_digit_cnt", 8'(bus.digit_cnt), 8'h0);
        chk("reset_locked", 8'(bus.locked), 8'h0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // correct PIN then A / B
        press_seq(32'h1234, 4);
        chk("four_digits", 8'(bus.digit_cnt), 8'd4);
        expect_cmd(KP_ARM, 1'b0);
        press_seq(32'hA, 1);
        chk("cnt_after_arm", 8'(bus.digit_cnt), 8'd0);
        expect_cmd(KP_DISARM, 1'b0);
        press_seq(32'h1234B, 5);

        // fifth digit keeps the newest four
        press_seq(32'h91234, 5);
        chk("cnt_saturates", 8'(bus.digit_cnt), 8'd4);
        expect_cmd(KP_DISARM, 1'b0);
        press_seq(32'hB, 1);

        // short entry, clear key, wrong PIN, ignored keys
        press_seq(32'h123, 3);
        chk("three_digits", 8'(bus.digit_cnt), 8'd3);
        expect_cmd(KP_NONE, 1'b1);
        press_seq(32'hA, 1);
        press_seq(32'h12C, 3);
        chk("clear_key", 8'(bus.digit_cnt), 8'd0);
        expect_cmd(KP_ARM, 1'b0);
        press_seq(32'h1234A, 5);
        expect_cmd(KP_NONE, 1'b1);
        press_seq(32'h1235B, 5);
        press_seq(32'h12E3F4D, 7);
        chk("ignored_keys", 8'(bus.digit_cnt), 8'd4);
        expect_cmd(KP_ARM, 1'b0);
        press_seq(32'hA, 1);

        // row bounce never settles
        bounce_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bounce_val = (i % 2 == 0) ? 4'b1110 : 4'b1111;
            repeat (2) @(negedge clk);
        end
        bounce_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce_no_key", 8'(bus.digit_cnt), 8'd0);

        // long hold yields a single digit
        press_hold(4'h1, 100);
        chk("long_hold_one", 8'(bus.digit_cnt), 8'd1);
        press_seq(32'hC, 1);

        // inactivity timeout
        press_seq(32'h12, 2);
        repeat (150) @(negedge clk);
        chk("before_timeout", 8'(bus.digit_cnt), 8'd2);
        repeat (60) @(negedge clk);
        chk("after_timeout", 8'(bus.digit_cnt), 8'd0);

        // clock enable low freezes the scanner
        bus.ENA = 1'b0;
        press_hold(4'h5, 40);
        bus.ENA = 1'b1;
        repeat (10) @(negedge clk);
        chk("ena_low_no_key", 8'(bus.digit_cnt), 8'd0);

        // asynchronous reset in the middle of a debounce
        press_seq(32'h12, 2);
        chk("pre_reset_cnt", 8'(bus.digit_cnt), 8'd2);
        @(negedge clk);
        locate(4'h3);
        pressed = 1'b1;
        begin
            int n;
            n = 0;
            while (bus.col_n !== 4'b1011 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("col_reached", 8'(bus.col_n), 8'hB);
        end
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("async_col_n", 8'(bus.col_n), 8'hE);
        chk("async_digit_cnt", 8'(bus.digit_cnt), 8'd0);
        chk("async_keypad", 8'(bus.keypad), 8'h0);
        chk("async_bad_pin", 8'(bus.bad_pin), 8'h0);
        @(negedge clk);
        pressed = 1'b0;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

`ifdef KEYPAD_LOCKOUT_EN
        for (int i = 0; i < 3; i++) begin
            expect_cmd(KP_NONE, 1'b1);
            press_seq(32'h1235A, 5);
        end
        chk("locked_set", 8'(bus.locked), 8'd1);
        press_seq(32'h1234, 4);
        chk("locked_discard", 8'(bus.digit_cnt), 8'd0);
        press_seq(32'hA, 1);
        chk("still_locked", 8'(bus.locked), 8'd1);
        repeat (150) @(negedge clk);
        chk("lock_expired", 8'(bus.locked), 8'd0);
        expect_cmd(KP_ARM, 1'b0);
        press_seq(32'h1234A, 5);
`else
        for (int i = 0; i < 3; i++) begin
            expect_cmd(KP_NONE, 1'b1);
            press_seq(32'h1235A, 5);
        end
        chk("no_lockout", 8'(bus.locked), 8'd0);
        expect_cmd(KP_ARM, 1'b0);
        press_seq(32'h1234A, 5);
`endif

        repeat (20) @(negedge clk);
        chk("scoreboard_drain", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
